key_schedule_gen: RTL and testbench

Iterative, parametrised AES key-schedule engine for AES-128, AES-192 and AES-256. It accepts a cipher key over a valid/ready handshake and expands it into all round keys at one 32-bit word per cycle. The round keys are held in an internal word store, and the cipher datapath reads any round key by index. It sits between the key-load interface and the CTR-mode round datapath, and replaces per-round combinational expansion.

---
 rtl/key_schedule_gen_pkg.sv | 46 ++++
 rtl/key_schedule_gen_sub_word.sv | 15 +
 rtl/key_schedule_gen.sv | 136 +++++++++++++
 tb/tb_key_schedule_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_schedule_gen_pkg.sv
// Shared AES constants and helpers for the key schedule and the round datapath:
// S-box table, xtime, legal key widths and the key-schedule FSM states.
package key_schedule_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } ks_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit is_legal_key_bits(input int bits);
        return (bits == 128) || (bits == 192) || (bits == 256);
    endfunction

endpackage

// File: rtl/key_schedule_gen_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module key_schedule_gen_sub_word
    import key_schedule_gen_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            sub[8*b +: 8] = sbox(word[8*b +: 8]);
        end
    end

endmodule

// File: rtl/key_schedule_gen.sv
// Iterative AES key expansion (128/192/256): one schedule word per cycle into a
// register word store, with a registered 128-bit round-key read port.
module key_schedule_gen
    import key_schedule_gen_pkg::*;
#(
    parameter int KEY_BITS = 128
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                sched_busy,
    output logic                sched_done,
    input  logic                rk_rd_en,
    input  logic [3:0]          rk_rd_idx,
    output logic                rk_valid,
    output logic [127:0]        rk_out,
    output logic                rk_err
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [5:0] LAST_W   = 6'(NW - 1);
    localparam logic [2:0] PH_LAST  = 3'(NK - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    if (!is_legal_key_bits(KEY_BITS)) begin : g_bad_key_bits
        $error("key_schedule_gen: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_t   state, state_next;
    logic [5:0]  word_idx;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic [31:0] w [NW];

    logic [31:0] w_prev, w_back, sub_in, sub_out, temp, w_new;
    logic [5:0]  rd_base;
    logic        rd_ok;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever the order of statements.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (key_valid) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_EXPAND;
            ST_EXPAND: if (word_idx == LAST_W) state_next = ST_DONE;
            ST_DONE:   if (key_valid) state_next = ST_LOAD;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign key_ready  = (state == ST_IDLE) || (state == ST_DONE);
    assign sched_busy = (state == ST_LOAD) || (state == ST_EXPAND);
    assign sched_done = (state == ST_DONE);

    // phase tracks word_idx mod NK so the expansion never needs a divider.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_idx <= '0;
            phase    <= '0;
            rcon     <= RCON_INIT;
        end else if (state == ST_LOAD) begin
            word_idx <= NK_W;
            phase    <= '0;
            rcon     <= RCON_INIT;
        end else if (state == ST_EXPAND) begin
            word_idx <= word_idx + 6'd1;
            phase    <= (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) rcon <= xtime(rcon);
        end
    end

    assign w_prev = w[word_idx - 6'd1];
    assign w_back = w[word_idx - NK_W];

    always_comb begin
        sub_in = w_prev;
        temp   = w_prev;
        if (phase == 3'd0) begin
            sub_in = {w_prev[23:0], w_prev[31:24]};
            temp   = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && phase == 3'd4) begin
            temp   = sub_out;
        end
        w_new = w_back ^ temp;
    end

    key_schedule_gen_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    // NOTE: the word store has no reset; a schedule is only readable in DONE,
    // after every word has been written from a fresh key.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key_in[KEY_BITS-1-32*k -: 32];
            end
        end else if (state == ST_EXPAND) begin
            w[word_idx] <= w_new;
        end
    end

    assign rd_base = {rk_rd_idx, 2'b00};
    assign rd_ok   = rk_rd_en && (state == ST_DONE) && (rk_rd_idx <= NR_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_out   <= '0;
        end else begin
            rk_valid <= rd_ok;
            rk_err   <= rk_rd_en && !rd_ok;
            if (rd_ok) begin
                rk_out <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench: three instances (AES-128/192/256) against a FIPS-197
// style reference model whose S-box is derived from GF(2^8) arithmetic.
module tb_key_schedule_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       kv, kr, busy, done, rd_en, rkv, rkerr;
    logic [2:0][255:0] kin;
    logic [2:0][3:0]   rd_idx;
    logic [2:0][127:0] rko;

    int errors  = 0;
    int checks  = 0;
    int elapsed = 0;

    logic [7:0]  sb [256];
    logic [31:0] exp_w [3][60];
    logic [255:0] key_a;

    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_schedule_gen #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]),
        .key_in(kin[0][255:128]), .sched_busy(busy[0]), .sched_done(done[0]),
        .rk_rd_en(rd_en[0]), .rk_rd_idx(rd_idx[0]), .rk_valid(rkv[0]),
        .rk_out(rko[0]), .rk_err(rkerr[0])
    );

    key_schedule_gen #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]),
        .key_in(kin[1][255:64]), .sched_busy(busy[1]), .sched_done(done[1]),
        .rk_rd_en(rd_en[1]), .rk_rd_idx(rd_idx[1]), .rk_valid(rkv[1]),
        .rk_out(rko[1]), .rk_err(rkerr[1])
    );

    key_schedule_gen #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]),
        .key_in(kin[2]), .sched_busy(busy[2]), .sched_done(done[2]),
        .rk_rd_en(rd_en[2]), .rk_rd_idx(rd_idx[2]), .rk_valid(rkv[2]),
        .rk_out(rko[2]), .rk_err(rkerr[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Key is left-aligned in 256 bits for every width.
    task automatic model_expand(input int d, input logic [255:0] key);
        int nk, nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * d;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) exp_w[d][i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = exp_w[d][i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            exp_w[d][i] = exp_w[d][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int d, input int j);
        return {exp_w[d][4*j], exp_w[d][4*j+1], exp_w[d][4*j+2], exp_w[d][4*j+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        elapsed++;
    endtask

    task automatic start_key(input int d, input logic [255:0] key);
        checks++;
        if (kr[d] !== 1'b1) begin
            errors++;
            $display("FAIL key_ready_before_load d=%0d: got %b expected 1", d, kr[d]);
        end
        kin[d] = key;
        kv[d]  = 1'b1;
        step();
        kv[d]  = 1'b0;
        elapsed = 1;
    endtask

    task automatic wait_done(input int d);
        int nk, want;
        nk   = 4 + 2 * d;
        want = 2 + 4 * (nk + 7) - nk;
        while (!done[d] && elapsed < 200) step();
        checks++;
        if (elapsed != want) begin
            errors++;
            $display("FAIL done_latency d=%0d: got %0d cycles expected %0d", d, elapsed, want);
        end
    endtask

    task automatic read_ok(input int d, input int j, input logic [127:0] want);
        rd_en[d]  = 1'b1;
        rd_idx[d] = 4'(j);
        step();
        rd_en[d]  = 1'b0;
        checks++;
        if (rkv[d] !== 1'b1 || rkerr[d] !== 1'b0 || rko[d] !== want) begin
            errors++;
            $display("FAIL read d=%0d idx=%0d: got v=%b e=%b %h expected v=1 e=0 %h",
                     d, j, rkv[d], rkerr[d], rko[d], want);
        end
    endtask

    task automatic read_all(input int d);
        for (int j = 0; j <= 10 + 2 * d; j++) read_ok(d, j, exp_rk(d, j));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; kv = '0; rd_en = '0; kin = '0; rd_idx = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({kr[d], busy[d], done[d], rkv[d], rkerr[d]} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_flags d=%0d: got %b expected 10000", d,
                         {kr[d], busy[d], done[d], rkv[d], rkerr[d]});
            end
            checks++;
            if (rko[d] !== 128'h0) begin
                errors++;
                $display("FAIL reset_rk_out d=%0d: got %h expected 0", d, rko[d]);
            end
        end
        rd_en[1] = 1'b1; rd_idx[1] = 4'd0;
        step();
        rd_en[1] = 1'b0;
        checks++;
        if (rkerr[1] !== 1'b1 || rkv[1] !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_reject: got err=%b v=%b expected err=1 v=0", rkerr[1], rkv[1]);
        end
    endtask

    task automatic test_aes128();
        logic [255:0] k;
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        model_expand(0, k);
        start_key(0, k);
        wait_done(0);
        read_ok(0, 0, k[255:128]);
        read_ok(0, 1, RK128_1);
        read_ok(0, 10, RK128_10);
    endtask

    task automatic test_aes192();
        logic [255:0] k;
        k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        model_expand(1, k);
        start_key(1, k);
        wait_done(1);
        read_ok(1, 12, RK192_12);
        k = {rand_key()} & {{192{1'b1}}, 64'h0};
        model_expand(1, k);
        start_key(1, k);
        wait_done(1);
        read_all(1);
    endtask

    task automatic test_aes256();
        logic [255:0] k;
        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        model_expand(2, k);
        start_key(2, k);
        wait_done(2);
        read_ok(2, 14, RK256_14);
        k = rand_key();
        model_expand(2, k);
        start_key(2, k);
        wait_done(2);
        read_all(2);
    endtask

    task automatic test_reject();
        key_a = {rand_key()} & {{128{1'b1}}, 128'h0};
        model_expand(0, key_a);
        start_key(0, key_a);
        step(); step(); step();
        kin[0] = rand_key();
        kv[0]  = 1'b1;
        step();
        checks++;
        if (kr[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_ready: got ready=%b busy=%b expected ready=0 busy=1", kr[0], busy[0]);
        end
        step();
        kv[0] = 1'b0;
        rd_en[0] = 1'b1; rd_idx[0] = 4'd3;
        step();
        rd_en[0] = 1'b0;
        checks++;
        if (rkerr[0] !== 1'b1 || rkv[0] !== 1'b0 || rko[0] !== RK128_10) begin
            errors++;
            $display("FAIL expand_read_reject: got err=%b v=%b %h expected err=1 v=0 %h",
                     rkerr[0], rkv[0], rko[0], RK128_10);
        end
        step();
        checks++;
        if (rkerr[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: got %b expected 0", rkerr[0]);
        end
        wait_done(0);
        rd_en[0] = 1'b1; rd_idx[0] = 4'd11;
        step();
        rd_en[0] = 1'b0;
        checks++;
        if (rkerr[0] !== 1'b1 || rkv[0] !== 1'b0 || rko[0] !== RK128_10) begin
            errors++;
            $display("FAIL idx11_reject: got err=%b v=%b %h expected err=1 v=0 %h",
                     rkerr[0], rkv[0], rko[0], RK128_10);
        end
        read_ok(0, 10, exp_rk(0, 10));
        read_ok(0, 4, exp_rk(0, 4));
    endtask

    task automatic test_back_to_back();
        rd_en[0] = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            rd_idx[0] = 4'(j);
            step();
            checks++;
            if (rkv[0] !== 1'b1 || rko[0] !== exp_rk(0, j) ||
                (j == 0 && rko[0] !== key_a[255:128])) begin
                errors++;
                $display("FAIL b2b_read idx=%0d: got v=%b %h expected v=1 %h", j, rkv[0], rko[0], exp_rk(0, j));
            end
        end
        rd_en[0] = 1'b0;
        step();
        checks++;
        if (rkv[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_drop: got %b expected 0", rkv[0]);
        end
    endtask

    task automatic test_rekey();
        logic [127:0] old_rk;
        logic [255:0] k;
        old_rk = exp_rk(0, 10);
        k = {rand_key()} & {{128{1'b1}}, 128'h0};
        kin[0] = k; kv[0] = 1'b1;
        rd_en[0] = 1'b1; rd_idx[0] = 4'd10;
        step();
        kv[0] = 1'b0; rd_en[0] = 1'b0;
        elapsed = 1;
        checks++;
        if (rkv[0] !== 1'b1 || rko[0] !== old_rk) begin
            errors++;
            $display("FAIL rekey_old_read: got v=%b %h expected v=1 %h", rkv[0], rko[0], old_rk);
        end
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rekey_done_drop: got done=%b busy=%b expected done=0 busy=1", done[0], busy[0]);
        end
        model_expand(0, k);
        wait_done(0);
        read_all(0);
    endtask

    task automatic test_reset_mid();
        logic [255:0] k;
        k = {rand_key()} & {{128{1'b1}}, 128'h0};
        model_expand(0, k);
        start_key(0, k);
        for (int c = 0; c < 16; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({kr[0], busy[0], done[0]} !== 3'b100 || rko[0] !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid: got rdy/busy/done=%b %h expected 100 0", {kr[0], busy[0], done[0]}, rko[0]);
        end
        k = {rand_key()} & {{128{1'b1}}, 128'h0};
        model_expand(0, k);
        start_key(0, k);
        wait_done(0);
        read_all(0);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_reject();
        test_back_to_back();
        test_rekey();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
